// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to instruction memory, a
// single-entry buffer toward decode, redirect handling and a sticky misalign fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_fault,
  output logic [1:0]  state_dbg
);

  // Handshakes: imem_req/imem_addr stay stable until imem_ack (ack is ignored
  // while imem_req=0); instr_valid/instr_out/instr_pc stay stable until
  // instr_ready, and a transfer happens on any edge where both are high.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic        bad_redirect;

  assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);

  // All outputs decode directly from registered state, so they are glitch-free.
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = (state == DRAIN) ? drain_addr : pc;
  assign instr_valid = (state == HOLD);
  assign opcode      = instr_out[6:0];
  assign func3       = instr_out[14:12];
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      drain_addr     <= 32'h0;
      instr_out      <= 32'h0000_0013;
      instr_pc       <= 32'h0;
      misalign_fault <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bad_redirect) begin
            state          <= FAULT;
            misalign_fault <= 1'b1;
          end else if (redirect) begin
            pc <= redirect_pc;
            // An unacked request must still complete on the bus at its old address.
            if (!imem_ack) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (imem_ack) begin
            instr_out <= imem_rdata;
            instr_pc  <= pc;
            pc        <= pc + 32'd4;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bad_redirect) begin
            state          <= FAULT;
            misalign_fault <= 1'b1;
          end else if (redirect) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end else if (instr_ready) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (bad_redirect) begin
            state          <= FAULT;
            misalign_fault <= 1'b1;
          end else begin
            if (redirect) pc <= redirect_pc;
            if (imem_ack) state <= FETCH;
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, delivery, backpressure, drain, redirects,
// address wrap and the sticky misalign fault.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_fault;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int deliveries = 0;

  localparam logic [1:0] S_FETCH = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2, S_FAULT = 2'd3;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_fault(misalign_fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) deliveries++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", {31'b0, misalign_fault}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, S_FETCH});

    // First fetch acked in its first cycle
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    step();
    check("first_valid", {31'b0, instr_valid}, 32'd1);
    check("first_instr_out", instr_out, 32'h0050_0093);
    check("first_instr_pc", instr_pc, 32'h0);
    check("first_opcode", {25'b0, opcode}, 32'h13);
    check("first_func3", {29'b0, func3}, 32'd0);
    check("first_req_hold", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    step();
    check("second_addr", imem_addr, 32'h4);
    check("second_valid", {31'b0, instr_valid}, 32'd0);
    check("deliv_1", deliveries, 32'd1);

    // Backpressure: decode stalls 5 cycles, stray ack while idle must be ignored
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00A1_2283;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_out", instr_out, 32'h00A1_2283);
      check("stall_pc", instr_pc, 32'h4);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    check("stall_opcode", {25'b0, opcode}, 32'h03);
    check("stall_func3", {29'b0, func3}, 32'd2);
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    check("after_stall_addr", imem_addr, 32'h8);
    check("deliv_2", deliveries, 32'd2);
    instr_ready = 1'b0;

    // Redirect while request pending: drain old address through a 3-cycle ack delay
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("drain_state", {30'b0, state_dbg}, {30'b0, S_DRAIN});
    check("drain_addr_0", imem_addr, 32'h8);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    step();
    check("drain_addr_1", imem_addr, 32'h8);
    step();
    check("drain_addr_2", imem_addr, 32'h8);
    check("drain_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    check("post_drain_addr", imem_addr, 32'h100);
    check("post_drain_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    step();
    check("post_drain_idle_valid", {31'b0, instr_valid}, 32'd0);
    check("post_drain_idle_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h0000_4033;
    step();
    imem_ack = 1'b0;
    check("tgt_instr_pc", instr_pc, 32'h100);
    check("tgt_instr_out", instr_out, 32'h0000_4033);
    check("tgt_func3", {29'b0, func3}, 32'd4);

    // Redirect and ready together in HOLD: one delivery, fetch from target
    redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    check("rr_addr", imem_addr, 32'h200);
    check("rr_valid", {31'b0, instr_valid}, 32'd0);
    check("deliv_3", deliveries, 32'd3);

    // Redirect with ack in FETCH discards data; then fetch at top of address space
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("fack_state", {30'b0, state_dbg}, {30'b0, S_FETCH});
    check("fack_addr", imem_addr, 32'hFFFF_FFFC);
    check("fack_valid", {31'b0, instr_valid}, 32'd0);
    imem_rdata = 32'h0000_1063;
    step();
    imem_ack = 1'b0;
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr_out", instr_out, 32'h0000_1063);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);
    check("deliv_4", deliveries, 32'd4);

    // Successive redirects in DRAIN: newest wins, ack with redirect exits
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    check("d2_addr_a", imem_addr, 32'h0);
    redirect_pc = 32'h400;
    step();
    check("d2_addr_b", imem_addr, 32'h0);
    check("d2_state", {30'b0, state_dbg}, {30'b0, S_DRAIN});
    redirect_pc = 32'h500; imem_ack = 1'b1;
    step();
    redirect = 1'b0;
    check("d2_exit_addr", imem_addr, 32'h500);
    check("d2_exit_state", {30'b0, state_dbg}, {30'b0, S_FETCH});
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    check("pre_fault_pc", instr_pc, 32'h500);

    // Misaligned redirect in HOLD: sticky fault, everything ignored until reset
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    check("fault_flag", {31'b0, misalign_fault}, 32'd1);
    check("fault_valid", {31'b0, instr_valid}, 32'd0);
    check("fault_req", {31'b0, imem_req}, 32'd0);
    redirect_pc = 32'h600; imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_sticky", {31'b0, misalign_fault}, 32'd1);
      check("fault_req_hold", {31'b0, imem_req}, 32'd0);
      check("fault_state", {30'b0, state_dbg}, {30'b0, S_FAULT});
    end
    check("deliv_fault", deliveries, 32'd4);

    rst_n = 1'b0; redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    step();
    check("rst2_fault", {31'b0, misalign_fault}, 32'd0);
    check("rst2_req", {31'b0, imem_req}, 32'd1);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_instr_out", instr_out, 32'h0000_0013);
    check("rst2_instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
